// File: rtl/uart_pkg.sv
// Shared constants and types for the AXI4-Lite UART register front end.
package uart_pkg;

  // Register offsets within the 32-byte window (addr[4:2])
  localparam logic [2:0] RBR_THR = 3'd0;
  localparam logic [2:0] IER_DLM = 3'd1;
  localparam logic [2:0] IIR_FCR = 3'd2;
  localparam logic [2:0] LCR     = 3'd3;
  localparam logic [2:0] MCR     = 3'd4;
  localparam logic [2:0] LSR     = 3'd5;
  localparam logic [2:0] MSR     = 3'd6;
  localparam logic [2:0] SCR     = 3'd7;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // True when the address falls in the 32-byte window starting at base
  function automatic logic in_window(input logic [12:0] addr, input logic [12:0] base);
    return addr[12:5] == base[12:5];
  endfunction

endpackage

// File: rtl/axi_uart_regs.sv
// AXI4-Lite slave for the 16550-style UART register window.
//
// Write FSM:
//   state  | meaning
//   W_IDLE | collecting AW and W into holding regs; executes when both held
//   W_RESP | write done, bvalid high until bready
// Read FSM:
//   state  | meaning
//   R_IDLE | arready high, waiting for AR
//   R_DATA | rdata/rresp registered, rvalid high until rready
module axi_uart_regs
  import uart_pkg::*;
#(
  parameter logic [12:0] BASE = 13'h1000
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [12:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [12:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic [3:0]  iir_in,
  output logic        iir_rd,
  input  logic [7:0]  lsr_in,
  input  logic [7:0]  msr_in,
  output logic [7:0]  ier_o,
  output logic [7:0]  lcr_o,
  output logic [7:0]  mcr_o,
  output logic [7:0]  fcr_o,
  output logic        fcr_wr,
  output logic [15:0] divisor_o,
  output logic        ip2intc_irpt
);

  wr_state_t w_state, w_state_nxt;
  rd_state_t r_state, r_state_nxt;

  logic       ready_en;
  logic       aw_full, w_full;
  logic       aw_win_q;
  logic [2:0] aw_off_q;
  logic [7:0] w_data_q;
  logic       w_strb0_q;
  logic       aw_hs, w_hs, ar_hs, wr_exec;
  logic       ar_win;
  logic [2:0] ar_off;
  logic [7:0] rd_byte;
  logic       dlab;

  logic [7:0] ier_q, lcr_q, mcr_q, fcr_q, scr_q, dll_q, dlm_q;

  // Bits of the bus that carry nothing for an 8-bit register window
  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[31:8], s_axi_wstrb[3:1]};

  assign dlab         = lcr_q[7];
  assign ier_o        = ier_q;
  assign lcr_o        = lcr_q;
  assign mcr_o        = mcr_q;
  assign fcr_o        = fcr_q;
  assign divisor_o    = {dlm_q, dll_q};
  assign ip2intc_irpt = ~iir_in[0];

  assign ar_win = in_window(s_axi_araddr, BASE);
  assign ar_off = s_axi_araddr[4:2];

  // Hold readies low until the first edge after reset release
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  // Write FSM next state, channel readies and execute pulse
  always_comb begin
    w_state_nxt   = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_exec       = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = ready_en && !aw_full;
        s_axi_wready  = ready_en && !w_full;
        if (aw_full && w_full) begin
          wr_exec     = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // AW / W holding registers, filled independently and drained together
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_full   <= 1'b0;
      aw_win_q  <= 1'b0;
      aw_off_q  <= 3'd0;
      w_full    <= 1'b0;
      w_data_q  <= 8'h00;
      w_strb0_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full  <= 1'b1;
        aw_win_q <= in_window(s_axi_awaddr, BASE);
        aw_off_q <= s_axi_awaddr[4:2];
      end else if (wr_exec) begin
        aw_full  <= 1'b0;
      end
      if (w_hs) begin
        w_full    <= 1'b1;
        w_data_q  <= s_axi_wdata[7:0];
        w_strb0_q <= s_axi_wstrb[0];
      end else if (wr_exec) begin
        w_full    <= 1'b0;
      end
    end
  end

  // Register file commit, write strobes and B response
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ier_q       <= 8'h00;
      lcr_q       <= 8'h00;
      mcr_q       <= 8'h00;
      fcr_q       <= 8'h00;
      scr_q       <= 8'h00;
      dll_q       <= 8'h00;
      dlm_q       <= 8'h00;
      tx_data     <= 8'h00;
      tx_wr       <= 1'b0;
      fcr_wr      <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      tx_wr  <= 1'b0;
      fcr_wr <= 1'b0;
      if (wr_exec) begin
        s_axi_bresp <= aw_win_q ? RESP_OKAY : RESP_SLVERR;
        if (aw_win_q && w_strb0_q) begin
          case (aw_off_q)
            RBR_THR: begin
              if (dlab) dll_q <= w_data_q;
              else begin
                tx_data <= w_data_q;
                tx_wr   <= 1'b1;
              end
            end
            IER_DLM: begin
              if (dlab) dlm_q <= w_data_q;
              else      ier_q <= w_data_q;
            end
            IIR_FCR: begin
              fcr_q  <= w_data_q;
              fcr_wr <= 1'b1;
            end
            LCR:     lcr_q <= w_data_q;
            MCR:     mcr_q <= w_data_q;
            SCR:     scr_q <= w_data_q;
            default: ; // LSR and MSR are read-only
          endcase
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= R_IDLE;
    else                r_state <= r_state_nxt;
  end

  // Read FSM next state, arready/rvalid and accept-cycle read strobes
  always_comb begin
    r_state_nxt   = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ar_hs         = 1'b0;
    rx_rd         = 1'b0;
    iir_rd        = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = ready_en;
        ar_hs         = s_axi_arvalid && ready_en;
        if (ar_hs) begin
          r_state_nxt = R_DATA;
          rx_rd       = ar_win && (ar_off == RBR_THR) && !dlab;
          iir_rd      = ar_win && (ar_off == IIR_FCR);
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read data mux, decoded with the DLAB value current at accept time
  always_comb begin
    rd_byte = 8'h00;
    case (ar_off)
      RBR_THR: rd_byte = dlab ? dll_q : rx_data;
      IER_DLM: rd_byte = dlab ? dlm_q : ier_q;
      IIR_FCR: rd_byte = {fcr_q[0], fcr_q[0], 2'b00, iir_in};
      LCR:     rd_byte = lcr_q;
      MCR:     rd_byte = mcr_q;
      LSR:     rd_byte = lsr_in;
      MSR:     rd_byte = msr_in;
      SCR:     rd_byte = scr_q;
      default: rd_byte = 8'h00;
    endcase
  end

  // Capture read response on accept; held stable while rvalid waits
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rdata <= 32'h0;
      s_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rdata <= ar_win ? {24'h0, rd_byte} : 32'h0;
      s_axi_rresp <= ar_win ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule
